// File: rtl/csa_stream_accumulator.sv
// Frame accumulator: LANES operands/beat folded into redundant S/C via 3:2 rows, one CPA per frame.
// Result registered the cycle after the last beat; in_ready low until out handshake. Option: CSA_BEATCNT_EN adds out_beats.
module csa_stream_accumulator #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 3,
  parameter int SUM_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_WIDTH-1:0]   out_sum,
`ifdef CSA_BEATCNT_EN
  output logic [15:0]            out_beats,
`endif
  output logic                   out_ovf
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t               state;
  logic [SUM_WIDTH-1:0] s_q, c_q;
  logic                 ovf_acc;

  logic [SUM_WIDTH-1:0] row_s, row_c, row_x, row_maj;
  logic [SUM_WIDTH-1:0] s_nxt, c_nxt;
  logic                 drop;
  logic [SUM_WIDTH:0]   cpa;

  // Each lane is folded in by one 3:2 row; a majority bit at the MSB would shift
  // out of the carry vector, and since everything is unsigned that proves overflow.
  always_comb begin
    row_s   = s_q;
    row_c   = c_q;
    row_x   = '0;
    row_maj = '0;
    drop    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      row_x   = SUM_WIDTH'(in_data[k*WIDTH +: WIDTH]);
      row_maj = (row_s & row_c) | (row_s & row_x) | (row_c & row_x);
      row_s   = row_s ^ row_c ^ row_x;
      drop    = drop | row_maj[SUM_WIDTH-1];
      row_c   = {row_maj[SUM_WIDTH-2:0], 1'b0};
    end
    s_nxt = row_s;
    c_nxt = row_c;
  end

  assign cpa = {1'b0, s_q} + {1'b0, c_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      ovf_acc   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready) begin
            s_q     <= s_nxt;
            c_q     <= c_nxt;
            ovf_acc <= ovf_acc | drop;
            if (in_last) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= cpa[SUM_WIDTH-1:0];
          out_ovf   <= ovf_acc | cpa[SUM_WIDTH];
          s_q       <= '0;
          c_q       <= '0;
          ovf_acc   <= 1'b0;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef CSA_BEATCNT_EN
  logic [15:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      out_beats <= '0;
    end else if (state == RESOLVE) begin
      out_beats <= beat_cnt;
      beat_cnt  <= '0;
    end else if (state == ACCUM && in_valid && in_ready && beat_cnt != 16'hFFFF) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator with default parameters.
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_sum;
  logic        out_ovf;
`ifdef CSA_BEATCNT_EN
  logic [15:0] out_beats;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef CSA_BEATCNT_EN
    .out_beats (out_beats),
`endif
    .out_ovf   (out_ovf)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic send_beat(input logic [15:0] l0, l1, l2, input logic last);
    in_data  = {l2, l1, l0};
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 48'hDEAD_BEEF_CAFE;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 20'd0) begin errors++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    send_beat(16'd1, 16'd10, 16'd100, 1'b0);
    send_beat(16'd1000, 16'd10000, 16'd2, 1'b0);
    send_beat(16'd3, 16'd4, 16'd5, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_after_last got %b want 0", in_ready); end
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout out_valid got %b want 1", out_valid); end
    checks++; if (out_sum !== 20'd11125) begin errors++; $display("FAIL basic_sum got %0d want 11125", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
`ifdef CSA_BEATCNT_EN
    checks++; if (out_beats !== 16'd3) begin errors++; $display("FAIL basic_beats got %0d want 3", out_beats); end
`endif
    take_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
    checks++; if (out_sum !== 20'd11125) begin errors++; $display("FAIL basic_sum_hold got %0d want 11125", out_sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_single_max();
    bit ok;
    send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout out_valid got %b want 1", out_valid); end
    checks++; if (out_sum !== 20'h2FFFD) begin errors++; $display("FAIL single_sum got %h want 2fffd", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", out_ovf); end
    take_result();
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 6; i++) send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, (i == 5));
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout out_valid got %b want 1", out_valid); end
    checks++; if (out_sum !== 20'h1FFEE) begin errors++; $display("FAIL ovf_sum got %h want 1ffee", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", out_ovf); end
`ifdef CSA_BEATCNT_EN
    checks++; if (out_beats !== 16'd6) begin errors++; $display("FAIL ovf_beats got %0d want 6", out_beats); end
`endif
    take_result();
  endtask

  task automatic test_backpressure();
    bit ok;
    send_beat(16'd1, 16'd2, 16'd3, 1'b1);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout out_valid got %b want 1", out_valid); end
    // Next frame is offered while the result is still pending.
    in_data = {16'd9, 16'd8, 16'd7}; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_sum !== 20'd6) begin
        errors++; $display("FAIL bp_hold cyc %0d got valid %b sum %0d want 1/6", i, out_valid, out_sum);
      end
    end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf got %b want 0", out_ovf); end
    take_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_hs got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept in_ready got %b want 0", in_ready); end
    wait_out(ok);
    checks++; if (!ok || out_sum !== 20'd24) begin errors++; $display("FAIL bp_next_sum got %0d want 24", out_sum); end
    take_result();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    send_beat(16'd1, 16'd10, 16'd100, 1'b0);
    send_beat(16'd1000, 16'd10000, 16'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_sum !== 20'd0 || out_ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset got sum %0d ovf %b valid %b ready %b want 0/0/0/1", out_sum, out_ovf, out_valid, in_ready);
    end
    send_beat(16'd1, 16'd2, 16'd3, 1'b1);
    wait_out(ok);
    checks++; if (!ok || out_sum !== 20'd6) begin errors++; $display("FAIL midreset_sum got %0d want 6", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %b want 0", out_ovf); end
    take_result();
  endtask

  task automatic test_gaps();
    bit ok;
    idle(2);
    send_beat(16'd1, 16'd10, 16'd100, 1'b0);
    idle(3);
    send_beat(16'd1000, 16'd10000, 16'd2, 1'b0);
    idle(1);
    send_beat(16'd3, 16'd4, 16'd5, 1'b1);
    wait_out(ok);
    checks++; if (!ok || out_sum !== 20'd11125) begin errors++; $display("FAIL gaps_sum got %0d want 11125", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL gaps_ovf got %b want 0", out_ovf); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_max();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
